dual_port_ram_param: RTL and testbench
======================================

Name: dual_port_ram_param

Overview:
- Parametrised true dual-port synchronous RAM; successor to the fixed 8-bit/256-word dual-port RAM.
- Adds:
  - configurable width and depth
  - per-port read enable with a valid strobe
  - a selectable read-during-write mode
  - deterministic write-write collision arbitration with a saturating collision counter
  - a post-reset memory-clear sequencer
- Sits as generic on-chip storage between two independent masters sharing one clock.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
- INIT_VAL, 0, DATA_W-bit value written to every word during the post-reset clear.
- CNT_W, 8, collision counter width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- w_en1  in  1  port 1 write enable.
- r_en1  in  1  port 1 read enable.
- addr1  in  ADDR_W  port 1 address.
- data_in1  in  DATA_W  port 1 write data.
- data_out1  out  DATA_W  port 1 registered read data.
- rd_valid1  out  1  port 1 read-data valid, one-cycle pulse.
- w_en2, r_en2, addr2, data_in2, data_out2, rd_valid2  as port 1, for port 2.
- init_busy  out  1  high while the clear sequencer runs; ports are ignored.
- collision  out  1  one-cycle pulse on a same-address write-write collision.
- collision_cnt  out  CNT_W  saturating count of collisions since reset.
- par_err1, par_err2  out  1  parity error on the read word, aligned with rd_validN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_out1/2 = 0, rd_valid1/2 = 0, collision = 0, collision_cnt = 0, par_err1/2 = 0.
  - init_busy = 1; FSM enters ST_INIT with init_addr = 0.
  - Array contents are not reset directly.
- ST_INIT:
  - Each cycle: mem[init_addr] <= INIT_VAL, init_addr increments.
  - After writing address DEPTH-1, go to ST_READY next cycle; init_busy falls the same edge.
  - Clear takes exactly DEPTH cycles after reset release.
  - All w_en/r_en inputs are ignored; rd_valid stays 0.
- ST_READY: the two ports act independently each cycle.
- Write: on the edge with w_enN = 1, mem[addrN] <= data_inN.
- Read, latency 1:
  - r_enN = 1 at edge k -> data_outN and rd_validN = 1 after edge k.
  - r_enN = 0 -> data_outN holds its last value; rd_validN = 0.
- Same-port read and write to the same address: RDW_MODE 0 returns the old word; RDW_MODE 1 returns data_inN.
- Cross-port read of an address being written by the other port: returns the old word, regardless of RDW_MODE.
- Write-write to the same address:
  - Port 1 wins; port 2's write is dropped.
  - collision pulses for one cycle.
  - collision_cnt increments and saturates at 2**CNT_W-1.
- Different-address simultaneous writes: both commit; no collision.
- Address wrap is natural (ADDR_W bits); no out-of-range case exists.
- Reset mid-operation: the FSM restarts ST_INIT and the full clear repeats; in-flight reads are discarded (rd_valid = 0).
- No state persists in the FSM beyond ST_INIT/ST_READY.

Optional Feature:
- Macro DPRAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on every write including the init clear.
  - On read, parity is recomputed over the stored data and compared with the stored bit.
  - A mismatch sets par_errN = 1 in the same cycle as rd_validN.
- Undefined: no parity storage; par_err1/2 are tied to 0.
- Ports are identical in both builds.

Decomposition:
- Package dpram_pkg:
  - FSM state enum ST_INIT, ST_READY.
  - RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1 constants.
  - A parity helper function.
- One sub-module, dpram_init_ctrl:
  - Owns the FSM, init_addr counter and init_busy.
  - Drives an internal write-override path into the array.
- Storage, port logic and collision logic stay in the top module.

Test Plan:
- Reset, then hold rst_n high (DEPTH = 256, INIT_VAL = 8'hA5):
  - init_busy is high for exactly 256 cycles.
  - A port 1 read of addresses 0, 17 and 255 returns 8'hA5 with rd_valid1 pulsing.
- Port 1 writes 8'd7 @4, port 2 writes 8'd9 @5 (different cycles), then both read their own address: data_out1 = 7 and data_out2 = 9 one cycle after r_en.
- Both ports write @4 in the same cycle (port 1: 8'h11, port 2: 8'h22):
  - collision pulses one cycle; collision_cnt = 1.
  - A subsequent read @4 returns 8'h11.
- Word @8 holds 8'h33; in one cycle port 1 writes 8'h44 @8 with r_en1 = 1 and port 2 reads @8:
  - RDW_MODE = 0: data_out1 = 8'h33.
  - RDW_MODE = 1: data_out1 = 8'h44.
  - data_out2 = 8'h33 in both modes.
- CNT_W = 2 with 5 collisions: collision_cnt saturates at 3. Then assert rst_n low mid-read: outputs go to 0 immediately and init_busy rises.
- DPRAM_PARITY_EN defined: force a bit flip in a stored word via hierarchical access, read it, and require par_err1 = 1 with rd_valid1. A clean read gives par_err1 = 0.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
// DPRAM_PARITY_EN (optional) adds a stored even-parity bit per word.
package dpram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Even-parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dpram_init_ctrl.sv
// Post-reset clear sequencer: sweeps every address once, then hands the array to the ports.
module dpram_init_ctrl
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  output logic              init_we_c,
  output logic [ADDR_W-1:0] init_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  // State register; init_busy mirrors the next state so it falls on the last clear edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_addr <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_nxt;
      init_addr <= addr_nxt;
      init_busy <= (state_nxt == ST_INIT);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_addr == LAST_ADDR) begin
      state_nxt = ST_READY;
    end
  end

  always_comb begin
    init_we_c = 1'b0;
    addr_nxt  = init_addr;
    if (state == ST_INIT) begin
      init_we_c = 1'b1;
      addr_nxt  = init_addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port RAM with clear sequencer, collision arbitration and
// optional per-word even parity (DPRAM_PARITY_EN).
module dual_port_ram_param
  import dpram_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int unsigned       CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en1,
  input  logic              r_en1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data_in1,
  output logic [DATA_W-1:0] data_out1,
  output logic              rd_valid1,
  input  logic              w_en2,
  input  logic              r_en2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data_in2,
  output logic [DATA_W-1:0] data_out2,
  output logic              rd_valid2,
  output logic              init_busy,
  output logic              collision,
  output logic [CNT_W-1:0]  collision_cnt,
  output logic              par_err1,
  output logic              par_err2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef DPRAM_PARITY_EN
  localparam int unsigned STORE_W = DATA_W + 1;
`else
  localparam int unsigned STORE_W = DATA_W;
`endif
  localparam logic WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  logic [STORE_W-1:0] mem [DEPTH];

  logic              init_we_c;
  logic [ADDR_W-1:0] init_addr;
  logic              ready_c;
  logic              ww_hit_c;
  logic [STORE_W-1:0] rd_word1_c;
  logic [STORE_W-1:0] rd_word2_c;

  function automatic logic [STORE_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef DPRAM_PARITY_EN
    return {even_parity(64'(d)), d};
`else
    return d;
`endif
  endfunction

  dpram_init_ctrl #(.ADDR_W(ADDR_W)) u_init_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .init_we_c (init_we_c),
    .init_addr (init_addr)
  );

  assign ready_c    = !init_busy;
  assign ww_hit_c   = ready_c && w_en1 && w_en2 && (addr1 == addr2);
  assign rd_word1_c = mem[addr1];
  assign rd_word2_c = mem[addr2];

  // Array writes: clear sweep overrides both ports; port 1 wins a same-address collision.
  always_ff @(posedge clk) begin
    if (init_we_c) begin
      mem[init_addr] <= encode(INIT_VAL);
    end else begin
      if (w_en2 && !ww_hit_c) mem[addr2] <= encode(data_in2);
      if (w_en1)              mem[addr1] <= encode(data_in1);
    end
  end

  // Read ports; a cross-port write never bypasses, so it always returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out1 <= '0;
      data_out2 <= '0;
      rd_valid1 <= 1'b0;
      rd_valid2 <= 1'b0;
    end else begin
      rd_valid1 <= ready_c && r_en1;
      rd_valid2 <= ready_c && r_en2;
      if (ready_c && r_en1) begin
        data_out1 <= (WRITE_FIRST && w_en1) ? data_in1 : rd_word1_c[DATA_W-1:0];
      end
      if (ready_c && r_en2) begin
        data_out2 <= (WRITE_FIRST && w_en2) ? data_in2 : rd_word2_c[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else begin
      collision <= ww_hit_c;
      if (ww_hit_c && collision_cnt != '1) begin
        collision_cnt <= collision_cnt + CNT_W'(1);
      end
    end
  end

`ifdef DPRAM_PARITY_EN
  // Bypassed write-first data is freshly encoded, so only array reads can flag an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err1 <= 1'b0;
      par_err2 <= 1'b0;
    end else begin
      par_err1 <= ready_c && r_en1 && !(WRITE_FIRST && w_en1) &&
                  (even_parity(64'(rd_word1_c[DATA_W-1:0])) != rd_word1_c[DATA_W]);
      par_err2 <= ready_c && r_en2 && !(WRITE_FIRST && w_en2) &&
                  (even_parity(64'(rd_word2_c[DATA_W-1:0])) != rd_word2_c[DATA_W]);
    end
  end
`else
  assign par_err1 = 1'b0;
  assign par_err2 = 1'b0;
`endif

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench: a read-first and a write-first instance driven in lockstep.
module tb_dual_port_ram_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w_en1, r_en1, w_en2, r_en2;
  logic [7:0] addr1, addr2, data_in1, data_in2;

  logic [7:0] data_out1_a, data_out2_a, data_out1_b, data_out2_b;
  logic       rd_valid1_a, rd_valid2_a, rd_valid1_b, rd_valid2_b;
  logic       init_busy_a, init_busy_b, collision_a, collision_b;
  logic [1:0] collision_cnt_a, collision_cnt_b;
  logic       par_err1_a, par_err2_a, par_err1_b, par_err2_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(0), .INIT_VAL(8'hA5), .CNT_W(2)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .w_en1(w_en1), .r_en1(r_en1), .addr1(addr1), .data_in1(data_in1),
    .data_out1(data_out1_a), .rd_valid1(rd_valid1_a),
    .w_en2(w_en2), .r_en2(r_en2), .addr2(addr2), .data_in2(data_in2),
    .data_out2(data_out2_a), .rd_valid2(rd_valid2_a),
    .init_busy(init_busy_a), .collision(collision_a), .collision_cnt(collision_cnt_a),
    .par_err1(par_err1_a), .par_err2(par_err2_a)
  );

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(8), .RDW_MODE(1), .INIT_VAL(8'hA5), .CNT_W(2)) u_wf (
    .clk(clk), .rst_n(rst_n),
    .w_en1(w_en1), .r_en1(r_en1), .addr1(addr1), .data_in1(data_in1),
    .data_out1(data_out1_b), .rd_valid1(rd_valid1_b),
    .w_en2(w_en2), .r_en2(r_en2), .addr2(addr2), .data_in2(data_in2),
    .data_out2(data_out2_b), .rd_valid2(rd_valid2_b),
    .init_busy(init_busy_b), .collision(collision_b), .collision_cnt(collision_cnt_b),
    .par_err1(par_err1_b), .par_err2(par_err2_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en1 = 1'b0; r_en1 = 1'b0; w_en2 = 1'b0; r_en2 = 1'b0;
  endtask

  // Counts busy cycles after release while port inputs hammer address 0.
  task automatic release_and_clear(input string tag);
    int  cnt;
    logic seen_vld, seen_col;
    cnt = 0; seen_vld = 1'b0; seen_col = 1'b0;
    w_en1 = 1'b1; r_en1 = 1'b1; addr1 = 8'd0; data_in1 = 8'h55;
    w_en2 = 1'b1; r_en2 = 1'b1; addr2 = 8'd0; data_in2 = 8'h66;
    @(posedge clk); #1;
    rst_n = 1'b1;
    while (init_busy_a && cnt < 1000) begin
      tick();
      cnt++;
      seen_vld |= rd_valid1_a | rd_valid2_a | rd_valid1_b;
      seen_col |= collision_a;
    end
    idle();
    check({tag, "_busy_cycles"}, 32'(cnt), 32'd256);
    check({tag, "_busy_b"}, 32'(init_busy_b), 32'd0);
    check({tag, "_no_valid"}, 32'(seen_vld), 32'd0);
    check({tag, "_no_collision"}, 32'(seen_col), 32'd0);
  endtask

  task automatic read1(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr1 = a; r_en1 = 1'b1;
    tick();
    r_en1 = 1'b0;
    check({tag, "_data"}, 32'(data_out1_a), 32'(exp));
    check({tag, "_valid"}, 32'(rd_valid1_a), 32'd1);
    check({tag, "_perr"}, 32'(par_err1_a), 32'd0);
  endtask

  logic [1:0] sat_exp [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst_n = 1'b0;
    idle();
    addr1 = '0; addr2 = '0; data_in1 = '0; data_in2 = '0;
    #12;
    check("rst_data1", 32'(data_out1_a), 32'd0);
    check("rst_valid1", 32'(rd_valid1_a), 32'd0);
    check("rst_busy", 32'(init_busy_a), 32'd1);
    check("rst_cnt", 32'(collision_cnt_a), 32'd0);
    check("rst_coll", 32'(collision_a), 32'd0);

    release_and_clear("init1");
    read1("rd0", 8'd0, 8'hA5);
    read1("rd17", 8'd17, 8'hA5);
    read1("rd255", 8'd255, 8'hA5);
    tick();
    check("rd_valid_drop", 32'(rd_valid1_a), 32'd0);
    check("rd_hold", 32'(data_out1_a), 32'hA5);

    // Separate-cycle writes, then both ports read their own address.
    w_en1 = 1'b1; addr1 = 8'd4; data_in1 = 8'd7;
    tick(); idle();
    w_en2 = 1'b1; addr2 = 8'd5; data_in2 = 8'd9;
    tick(); idle();
    check("sep_no_coll", 32'(collision_a), 32'd0);
    r_en1 = 1'b1; addr1 = 8'd4; r_en2 = 1'b1; addr2 = 8'd5;
    tick(); idle();
    check("sep_out1", 32'(data_out1_a), 32'd7);
    check("sep_out2", 32'(data_out2_a), 32'd9);
    check("sep_valid2", 32'(rd_valid2_a), 32'd1);

    // Simultaneous writes to different addresses both commit.
    w_en1 = 1'b1; addr1 = 8'd6; data_in1 = 8'h66;
    w_en2 = 1'b1; addr2 = 8'd7; data_in2 = 8'h77;
    tick(); idle();
    check("diff_no_coll", 32'(collision_a), 32'd0);
    check("diff_cnt", 32'(collision_cnt_a), 32'd0);
    r_en1 = 1'b1; addr1 = 8'd7; r_en2 = 1'b1; addr2 = 8'd6;
    tick(); idle();
    check("diff_out1", 32'(data_out1_a), 32'h77);
    check("diff_out2", 32'(data_out2_a), 32'h66);

    // Same-address collision: port 1 wins.
    w_en1 = 1'b1; addr1 = 8'd4; data_in1 = 8'h11;
    w_en2 = 1'b1; addr2 = 8'd4; data_in2 = 8'h22;
    tick(); idle();
    check("coll_pulse", 32'(collision_a), 32'd1);
    check("coll_cnt", 32'(collision_cnt_a), 32'd1);
    tick();
    check("coll_pulse_end", 32'(collision_a), 32'd0);
    r_en1 = 1'b1; addr1 = 8'd4; r_en2 = 1'b1; addr2 = 8'd4;
    tick(); idle();
    check("coll_win1", 32'(data_out1_a), 32'h11);
    check("coll_win2", 32'(data_out2_a), 32'h11);

    // Read-during-write on port 1 with a cross-port read of the same word.
    w_en1 = 1'b1; addr1 = 8'd8; data_in1 = 8'h33;
    tick(); idle();
    w_en1 = 1'b1; r_en1 = 1'b1; addr1 = 8'd8; data_in1 = 8'h44;
    r_en2 = 1'b1; addr2 = 8'd8;
    tick(); idle();
    check("rdw1_rf", 32'(data_out1_a), 32'h33);
    check("rdw1_wf", 32'(data_out1_b), 32'h44);
    check("xrd_rf", 32'(data_out2_a), 32'h33);
    check("xrd_wf", 32'(data_out2_b), 32'h33);
    r_en2 = 1'b1; addr2 = 8'd8;
    tick(); idle();
    check("rdw1_commit", 32'(data_out2_a), 32'h44);

    // Read-during-write on port 2.
    w_en2 = 1'b1; r_en2 = 1'b1; addr2 = 8'd9; data_in2 = 8'h5A;
    tick(); idle();
    check("rdw2_rf", 32'(data_out2_a), 32'hA5);
    check("rdw2_wf", 32'(data_out2_b), 32'h5A);
    check("rdw2_valid", 32'(rd_valid2_b), 32'd1);

    // Four more collisions: the 2-bit counter saturates at 3.
    for (int i = 0; i < 4; i++) begin
      w_en1 = 1'b1; addr1 = 8'(10 + i); data_in1 = 8'(i);
      w_en2 = 1'b1; addr2 = 8'(10 + i); data_in2 = 8'(i + 1);
      tick(); idle();
      check("sat_cnt", 32'(collision_cnt_a), 32'(sat_exp[i]));
    end
    check("sat_cnt_b", 32'(collision_cnt_b), 32'd3);

`ifdef DPRAM_PARITY_EN
    u_rf.mem[20][0] = ~u_rf.mem[20][0];
    addr1 = 8'd20; r_en1 = 1'b1;
    tick(); idle();
    check("par_err_flip", 32'(par_err1_a), 32'd1);
    check("par_err_valid", 32'(rd_valid1_a), 32'd1);
    read1("par_clean", 8'd17, 8'hA5);
`endif

    // Asynchronous reset in the middle of a read stream.
    r_en1 = 1'b1; addr1 = 8'd4;
    tick();
    check("pre_rst_data", 32'(data_out1_a), 32'h11);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_data1", 32'(data_out1_a), 32'd0);
    check("arst_data1_b", 32'(data_out1_b), 32'd0);
    check("arst_valid1", 32'(rd_valid1_a), 32'd0);
    check("arst_busy", 32'(init_busy_a), 32'd1);
    check("arst_cnt", 32'(collision_cnt_a), 32'd0);
    tick();
    check("arst_hold_valid", 32'(rd_valid1_a), 32'd0);
    release_and_clear("init2");
    read1("reclear4", 8'd4, 8'hA5);
    read1("reclear8", 8'd8, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
